hack_screen_vga: RTL and testbench

- Scans a 512x256 monochrome Hack-style framebuffer and produces a 640x480@60 Hz VGA signal with a 1-bit colour output.
- The framebuffer is an external 8K x 16 dual-port VRAM. This block reads it through its own read-only port; the CPU owns the other port.
- The image is centred in the 640x480 raster, with black borders around it.

---
 rtl/hack_screen_vga.sv | 167 ++++++++++++++++
 tb/tb_hack_screen_vga.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hack_screen_vga.sv
// hack_screen_vga
// Scans a 512x256 one-bit-per-pixel framebuffer held in an external 8K x 16
// VRAM and produces a 640x480@60 Hz VGA raster. The image sits centred on a
// black border. The VRAM is read through a read-only port with one clk of
// read latency. The pixel rate is half of clk.
module hack_screen_vga #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int IMG_X0 = 64,
    parameter int IMG_Y0 = 112,
    parameter int IMG_H  = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_vram,
    output logic [12:0] address_vram,
    output logic        hsync,
    output logic        vsync,
    output logic        rgb
);

    localparam int IMG_W = 512;
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST  = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOT - 1);
    localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC);

    // Horizontal positions are measured from the start of the fetch window,
    // which opens one 16-pixel group ahead of the first image column. The
    // image itself therefore spans fx = 16 .. 16+IMG_W-1 on this scale.
    localparam logic [9:0] FX_BEG  = 10'(IMG_X0 - 16);
    localparam logic [9:0] FX_LEN  = 10'(IMG_W);
    localparam logic [9:0] IX_BEG  = 10'd16;
    localparam logic [9:0] IX_END  = 10'(IMG_W + 16);
    localparam logic [9:0] IY_BEG  = 10'(IMG_Y0);
    localparam logic [9:0] IY_LEN  = 10'(IMG_H);

    logic        pix_en;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [9:0]  h_nxt;
    logic [9:0]  v_nxt;
    logic [15:0] shift;

    logic [9:0]  cur_fx;
    logic [9:0]  cur_iy;
    logic        cur_in_img;

    logic [9:0]  nxt_fx;
    logic [9:0]  nxt_iy;
    logic        nxt_row;
    logic        nxt_in_fetch;
    logic        nxt_grp_start;
    logic [12:0] nxt_addr;

    logic        hsync_next;
    logic        vsync_next;
    logic        rgb_next;

    // Raster position the counters move to on the next pixel tick.
    always_comb begin
        h_nxt = hcount + 10'd1;
        v_nxt = vcount;
        if (hcount == H_LAST) begin
            h_nxt = '0;
            if (vcount == V_LAST) begin
                v_nxt = '0;
            end else begin
                v_nxt = vcount + 10'd1;
            end
        end
    end

    // Window decode for the current position (drives the output stage) and
    // for the next position (drives fetch and shift-register load, so they
    // line up with the counters after the tick).
    always_comb begin
        cur_fx        = hcount - FX_BEG;
        cur_iy        = vcount - IY_BEG;
        cur_in_img    = (cur_iy < IY_LEN) && (cur_fx >= IX_BEG) && (cur_fx < IX_END);

        nxt_fx        = h_nxt - FX_BEG;
        nxt_iy        = v_nxt - IY_BEG;
        nxt_row       = (nxt_iy < IY_LEN);
        nxt_in_fetch  = nxt_row && (nxt_fx < FX_LEN);
        nxt_grp_start = nxt_row && (nxt_fx >= IX_BEG) && (nxt_fx < IX_END)
                        && (nxt_fx[3:0] == 4'd0);
        nxt_addr      = {nxt_iy[7:0], nxt_fx[8:4]};
    end

    // Next values of the registered outputs, taken from the current position.
    always_comb begin
        hsync_next = ~((hcount >= HS_BEG) && (hcount < HS_END));
        vsync_next = ~((vcount >= VS_BEG) && (vcount < VS_END));
        rgb_next   = cur_in_img & ~shift[0];
    end

    // Pixel enable: clk/2, low on the first clk after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_en <= 1'b0;
        end else begin
            pix_en <= ~pix_en;
        end
    end

    // Raster counters, advanced once per pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount <= '0;
            vcount <= '0;
        end else if (pix_en) begin
            hcount <= h_nxt;
            vcount <= v_nxt;
        end
    end

    // VRAM address: one group ahead of the pixels being shown, held outside
    // the fetch window so the RAM port stays quiet during blanking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            address_vram <= '0;
        end else if (pix_en && nxt_in_fetch) begin
            address_vram <= nxt_addr;
        end
    end

    // Pixel shifter: a word is loaded as its group begins, bit 0 is the pixel
    // currently under the beam, and it moves right once per pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift <= '0;
        end else if (pix_en) begin
            if (nxt_grp_start) begin
                shift <= data_vram;
            end else begin
                shift <= {1'b0, shift[15:1]};
            end
        end
    end

    // Output stage: syncs and colour registered together, one pixel behind
    // the counters, so they stay mutually aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            rgb   <= 1'b0;
        end else if (pix_en) begin
            hsync <= hsync_next;
            vsync <= vsync_next;
            rgb   <= rgb_next;
        end
    end

endmodule

// File: tb/tb_hack_screen_vga.sv
// tb_hack_screen_vga
// Drives hack_screen_vga with a reduced vertical geometry (11-line frame,
// 5 image rows) and full horizontal timing, against a behavioural VRAM and a
// pixel-position model that feeds a scoreboard of expected outputs.
module tb_hack_screen_vga;

    localparam int V_VIS  = 7;
    localparam int V_FP   = 1;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 1;
    localparam int IMG_Y0 = 1;
    localparam int IMG_H  = 5;
    localparam int H_TOT  = 800;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int VS_B   = V_VIS + V_FP;
    localparam int VS_E   = V_VIS + V_FP + V_SYNC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_vram = '0;
    logic [12:0] address_vram;
    logic        hsync;
    logic        vsync;
    logic        rgb;

    logic [15:0] vram [0:8191];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        rgb;
        logic [12:0] addr;
    } exp_t;

    exp_t sb_q[$];

    bit   m_pe;
    int   m_h;
    int   m_v;
    logic m_hs;
    logic m_vs;
    logic m_rgb;
    int   m_addr;

    hack_screen_vga #(
        .V_VIS  (V_VIS),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP),
        .IMG_Y0 (IMG_Y0),
        .IMG_H  (IMG_H)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_vram    (data_vram),
        .address_vram (address_vram),
        .hsync        (hsync),
        .vsync        (vsync),
        .rgb          (rgb)
    );

    always #10 clk = ~clk;

    // Registered-output VRAM read port.
    always @(posedge clk) data_vram <= vram[address_vram];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic pix_model(int h, int v);
        int ix;
        int iy;
        logic [15:0] w;
        if (h < 64 || h >= 576 || v < IMG_Y0 || v >= IMG_Y0 + IMG_H) return 1'b0;
        ix = h - 64;
        iy = v - IMG_Y0;
        w  = vram[iy * 32 + ix / 16];
        return ~w[ix % 16];
    endfunction

    // Model: steps a pixel position every other clk and pushes the outputs
    // expected after each clk edge.
    always @(posedge clk) begin
        exp_t e;
        if (!rst_n) begin
            m_pe = 1'b0; m_h = 0; m_v = 0;
            m_hs = 1'b1; m_vs = 1'b1; m_rgb = 1'b0; m_addr = 0;
            sb_q.delete();
        end else begin
            if (m_pe) begin
                m_hs  = !(m_h >= 656 && m_h < 752);
                m_vs  = !(m_v >= VS_B && m_v < VS_E);
                m_rgb = pix_model(m_h, m_v);
                m_h++;
                if (m_h == H_TOT) begin
                    m_h = 0;
                    m_v = (m_v == V_TOT - 1) ? 0 : m_v + 1;
                end
                if (m_v >= IMG_Y0 && m_v < IMG_Y0 + IMG_H && m_h >= 48 && m_h < 560)
                    m_addr = (m_v - IMG_Y0) * 32 + (m_h - 48) / 16;
            end
            m_pe = !m_pe;
            e.hs   = m_hs;
            e.vs   = m_vs;
            e.rgb  = m_rgb;
            e.addr = 13'(m_addr);
            sb_q.push_back(e);
        end
    end

    // Checker: compares DUT outputs mid-cycle against reset values or the
    // oldest scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            check("rst_hsync", 32'(hsync), 32'd1);
            check("rst_vsync", 32'(vsync), 32'd1);
            check("rst_rgb",   32'(rgb),   32'd0);
            check("rst_addr",  32'(address_vram), 32'd0);
        end else if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("hsync", 32'(hsync), 32'(e.hs));
            check("vsync", 32'(vsync), 32'(e.vs));
            check("rgb",   32'(rgb),   32'(e.rgb));
            check("addr",  32'(address_vram), 32'(e.addr));
        end
    end

    task automatic assert_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        sb_q.delete();
    endtask

    task automatic release_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int t;
        int n;

        for (int i = 0; i < 8192; i++) vram[i] = 16'h0000;

        // Phase A: blank VRAM, raster timing from reset release.
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        release_reset();

        t = 0;
        while (hsync !== 1'b0 && t < 3000) begin @(posedge clk); t++; #1; end
        check("hsync_first_fall_clk", t, 1314);

        n = 0;
        while (hsync !== 1'b1 && n < 3000) begin @(posedge clk); n++; #1; end
        check("hsync_low_clk", n, 192);
        while (hsync !== 1'b0 && n < 5000) begin @(posedge clk); n++; #1; end
        check("hsync_period_clk", n, 1600);
        t += n;

        while (vsync !== 1'b0 && t < 40000) begin @(posedge clk); t++; #1; end
        check("vsync_first_fall_clk", t, 2 * (VS_B * H_TOT + 1));

        n = 0;
        while (vsync !== 1'b1 && n < 20000) begin @(posedge clk); n++; #1; end
        check("vsync_low_clk", n, V_SYNC * 2 * H_TOT);
        while (vsync !== 1'b0 && n < 40000) begin @(posedge clk); n++; #1; end
        check("vsync_period_clk", n, V_TOT * 2 * H_TOT);

        // Mid-frame reset while both syncs are active.
        n = 0;
        while (hsync !== 1'b0 && n < 2000) begin @(posedge clk); n++; #1; end
        check("pre_rst_hsync", 32'(hsync), 32'd0);
        check("pre_rst_vsync", 32'(vsync), 32'd0);
        assert_reset();
        #1;
        check("async_rst_hsync", 32'(hsync), 32'd1);
        check("async_rst_vsync", 32'(vsync), 32'd1);
        check("async_rst_rgb",   32'(rgb),   32'd0);
        check("async_rst_addr",  32'(address_vram), 32'd0);

        // Phase B: single black pixels at the first and last image positions.
        vram[0] = 16'h0001;
        vram[(IMG_H - 1) * 32 + 31] = 16'h8000;
        repeat (3) @(negedge clk);
        release_reset();
        repeat ((IMG_Y0 + IMG_H + 1) * 2 * H_TOT) @(posedge clk);

        // Phase C: random VRAM contents.
        assert_reset();
        for (int i = 0; i < 8192; i++) vram[i] = 16'($urandom);
        repeat (3) @(negedge clk);
        release_reset();
        repeat ((IMG_Y0 + IMG_H + 1) * 2 * H_TOT) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
